gfx_readback_dma: RTL and testbench

- DMA engine for the reverse path of the gfx copy DMA: copies a rectangle of pixels from VRAM into CPU RAM.
- Programmed through an 8-register window on the CPU bus.
- Shares the VRAM bus with the VGA scanout and uses VRAM only while i_free_vbus is high.
- Writes captured pixels into one 8K page of CPU RAM at linearly incrementing addresses, so the CPU sees a packed row-major image.

---
 rtl/gfx_dma_pkg.sv | 26 ++
 rtl/gfx_rb_regs.sv | 67 ++++++
 rtl/gfx_readback_dma.sv | 161 ++++++++++++++++
 tb/tb_gfx_readback_dma.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_dma_pkg.sv
// Shared constants and types for the gfx readback DMA: register map, CTRL bits, FSM states.
package gfx_dma_pkg;

   localparam int unsigned REG_ADDR_W = 3;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned VADDR_W    = 16;

   localparam logic [REG_ADDR_W-1:0] REG_SRC_X  = 3'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SRC_Y  = 3'd1;
   localparam logic [REG_ADDR_W-1:0] REG_DST_L  = 3'd2;
   localparam logic [REG_ADDR_W-1:0] REG_DST_H  = 3'd3;
   localparam logic [REG_ADDR_W-1:0] REG_WIDTH  = 3'd4;
   localparam logic [REG_ADDR_W-1:0] REG_HEIGHT = 3'd5;
   localparam logic [REG_ADDR_W-1:0] REG_RSVD   = 3'd6;
   localparam logic [REG_ADDR_W-1:0] REG_CTRL   = 3'd7;

   localparam int unsigned CTRL_START_BIT = 0;
   localparam int unsigned CTRL_ABORT_BIT = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/gfx_rb_regs.sv
// CPU register window for the readback DMA; configuration is frozen while a copy is active.
module gfx_rb_regs
   import gfx_dma_pkg::*;
#(
   parameter int unsigned CPU_ADDR_W = 13,
   parameter int unsigned PAGE_W     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_b,
   input  logic                  i_cpu_ce_b,
   input  logic                  i_cpu_we_b,
   input  logic [REG_ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0]     i_cpu_data,
   input  logic                  i_active,
   output logic [7:0]            o_src_x,
   output logic [7:0]            o_src_y,
   output logic [CPU_ADDR_W-1:0] o_dst,
   output logic [PAGE_W-1:0]     o_page,
   output logic [7:0]            o_width,
   output logic [7:0]            o_height,
   output logic                  o_start_c,
   output logic                  o_abort_c
);

   logic       wr_c;
   logic       cfg_wr_c;
   logic       ctrl_wr_c;
   logic [7:0] dst_l_q;
   logic [4:0] dst_h_q;

   assign wr_c      = !i_cpu_ce_b && !i_cpu_we_b;
   assign cfg_wr_c  = wr_c && !i_active;
   assign ctrl_wr_c = wr_c && (i_cpu_addr == REG_CTRL);

   // Start only launches from idle; abort only means something while busy.
   assign o_start_c = ctrl_wr_c && i_cpu_data[CTRL_START_BIT] && !i_active;
   assign o_abort_c = ctrl_wr_c && i_cpu_data[CTRL_ABORT_BIT] &&  i_active;

   assign o_dst = CPU_ADDR_W'({dst_h_q, dst_l_q});

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         o_src_x  <= '0;
         o_src_y  <= '0;
         dst_l_q  <= '0;
         dst_h_q  <= '0;
         o_page   <= '0;
         o_width  <= '0;
         o_height <= '0;
      end else if (cfg_wr_c) begin
         case (i_cpu_addr)
            REG_SRC_X:  o_src_x  <= i_cpu_data;
            REG_SRC_Y:  o_src_y  <= i_cpu_data;
            REG_DST_L:  dst_l_q  <= i_cpu_data;
            REG_DST_H: begin
               dst_h_q <= i_cpu_data[4:0];
               o_page  <= PAGE_W'(i_cpu_data[6:5]);
            end
            REG_WIDTH:  o_width  <= i_cpu_data;
            REG_HEIGHT: o_height <= i_cpu_data;
            REG_RSVD, REG_CTRL: ;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gfx_readback_dma.sv
// Readback DMA: walks a VRAM rectangle row-major in free bus slots and streams pixels into one CPU RAM page.
module gfx_readback_dma
   import gfx_dma_pkg::*;
#(
   parameter int unsigned CPU_ADDR_W = 13,
   parameter int unsigned PAGE_W     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_b,
   input  logic                  i_cpu_ce_b,
   input  logic                  i_cpu_we_b,
   input  logic [REG_ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0]     i_cpu_data,
   input  logic                  i_free_vbus,
   output logic                  o_addr_sel,
   output logic [VADDR_W-1:0]    o_vram_addr,
   output logic                  o_vram_oe_b,
   input  logic [DATA_W-1:0]     i_vram_data,
   output logic                  o_ram_drive,
   output logic [CPU_ADDR_W-1:0] o_ram_addr,
   output logic [PAGE_W-1:0]     o_ram_page,
   output logic [DATA_W-1:0]     o_ram_data,
   output logic                  o_ram_we_b,
   output logic                  o_active,
   output logic                  o_done
);

   logic [7:0]            src_x;
   logic [7:0]            src_y;
   logic [CPU_ADDR_W-1:0] dst;
   logic [PAGE_W-1:0]     page;
   logic [7:0]            width;
   logic [7:0]            height;
   logic                  start_c;
   logic                  abort_c;

   state_t                state_q;
   state_t                state_d;
   logic                  issue_c;
   logic                  active_c;
   logic                  last_c;

   logic [7:0]            col_q;
   logic [7:0]            row_q;
   logic [7:0]            cur_x_q;
   logic [7:0]            cur_y_q;
   logic [CPU_ADDR_W-1:0] cpu_addr_q;
   logic [CPU_ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0]     ram_data_q;
   logic                  we_q;
   logic                  done_q;

   gfx_rb_regs #(
      .CPU_ADDR_W (CPU_ADDR_W),
      .PAGE_W     (PAGE_W)
   ) u_regs (
      .i_clk      (i_clk),
      .i_rst_b    (i_rst_b),
      .i_cpu_ce_b (i_cpu_ce_b),
      .i_cpu_we_b (i_cpu_we_b),
      .i_cpu_addr (i_cpu_addr),
      .i_cpu_data (i_cpu_data),
      .i_active   (active_c),
      .o_src_x    (src_x),
      .o_src_y    (src_y),
      .o_dst      (dst),
      .o_page     (page),
      .o_width    (width),
      .o_height   (height),
      .o_start_c  (start_c),
      .o_abort_c  (abort_c)
   );

   assign last_c = (col_q == '0) && (row_q == '0);

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_c) state_d = RUN;
         RUN:     if (abort_c || (issue_c && last_c)) state_d = DRAIN;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An abort write blocks the issue in its own cycle so no pixel slips past it.
   always_comb begin
      issue_c  = 1'b0;
      active_c = 1'b0;
      case (state_q)
         RUN: begin
            active_c = 1'b1;
            issue_c  = i_free_vbus && !abort_c;
         end
         DRAIN:   active_c = 1'b1;
         default: ;
      endcase
   end

   // Column/row down-counters with independently wrapping 8-bit X/Y coordinates.
   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         col_q      <= '0;
         row_q      <= '0;
         cur_x_q    <= '0;
         cur_y_q    <= '0;
         cpu_addr_q <= '0;
      end else if (start_c) begin
         col_q      <= width;
         row_q      <= height;
         cur_x_q    <= src_x;
         cur_y_q    <= src_y;
         cpu_addr_q <= dst;
      end else if (issue_c) begin
         cpu_addr_q <= cpu_addr_q + CPU_ADDR_W'(1);
         if (col_q == '0) begin
            col_q   <= width;
            cur_x_q <= src_x;
            row_q   <= row_q - 8'd1;
            cur_y_q <= cur_y_q + 8'd1;
         end else begin
            col_q   <= col_q - 8'd1;
            cur_x_q <= cur_x_q + 8'd1;
         end
      end
   end

   // Capture stage: the write lands exactly one cycle after its VRAM read.
   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
      end else begin
         we_q   <= issue_c;
         done_q <= (state_q == DRAIN);
         if (issue_c) begin
            ram_addr_q <= cpu_addr_q;
            ram_data_q <= i_vram_data;
         end
      end
   end

   assign o_addr_sel  = issue_c;
   assign o_vram_oe_b = !issue_c;
   assign o_vram_addr = issue_c ? {cur_y_q, cur_x_q} : '0;
   assign o_active    = active_c;
   assign o_ram_drive = active_c;
   assign o_ram_addr  = ram_addr_q;
   assign o_ram_data  = ram_data_q;
   assign o_ram_page  = page;
   assign o_ram_we_b  = !we_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_gfx_readback_dma.sv
// Randomized bench for gfx_readback_dma against a row-major rectangle copy model.
module tb_gfx_readback_dma;

   logic        clk;
   logic        rst_b;
   logic        ce_b;
   logic        we_b;
   logic [2:0]  cpu_addr;
   logic [7:0]  cpu_data;
   logic        free;
   logic        addr_sel;
   logic [15:0] vram_addr;
   logic        oe_b;
   logic [7:0]  vram_data;
   logic        ram_drive;
   logic [12:0] ram_addr;
   logic [1:0]  ram_page;
   logic [7:0]  ram_data;
   logic        ram_we_b;
   logic        active;
   logic        done;

   logic [7:0]  vram [65536];
   assign vram_data = vram[vram_addr];

   gfx_readback_dma #(.CPU_ADDR_W(13), .PAGE_W(2)) dut (
      .i_clk       (clk),
      .i_rst_b     (rst_b),
      .i_cpu_ce_b  (ce_b),
      .i_cpu_we_b  (we_b),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_data  (cpu_data),
      .i_free_vbus (free),
      .o_addr_sel  (addr_sel),
      .o_vram_addr (vram_addr),
      .o_vram_oe_b (oe_b),
      .i_vram_data (vram_data),
      .o_ram_drive (ram_drive),
      .o_ram_addr  (ram_addr),
      .o_ram_page  (ram_page),
      .o_ram_data  (ram_data),
      .o_ram_we_b  (ram_we_b),
      .o_active    (active),
      .o_done      (done)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Bus-free pattern: 0 always free, 1 random, 2 repeating 1,0,0
   int free_mode = 0;
   int free_ph   = 0;
   always @(posedge clk) begin
      #1;
      case (free_mode)
         0: free = 1'b1;
         1: free = 1'($urandom_range(0, 1));
         default: begin
            free    = (free_ph == 0);
            free_ph = (free_ph + 1) % 3;
         end
      endcase
   end

   // Observation of the DUT's bus activity
   bit          mon_en = 0;
   bit          prev_iss;
   logic [15:0] prev_va;
   logic [1:0]  cur_page;
   int          done_cnt;
   logic [15:0] iss_va [$];
   logic [12:0] wr_ca  [$];
   logic [7:0]  wr_d   [$];

   always @(negedge clk) begin
      if (mon_en) begin
         if (ram_we_b == 1'b0) begin
            chk("write_follows_issue", 32'(prev_iss), 1);
            if (prev_iss) chk("write_data_latency", ram_data, vram[prev_va]);
            chk("write_page", ram_page, cur_page);
            wr_ca.push_back(ram_addr);
            wr_d.push_back(ram_data);
         end
         if (addr_sel) begin
            chk("issue_on_busy_bus", 32'(free), 1);
            chk("issue_oe_b", 32'(oe_b), 0);
            iss_va.push_back(vram_addr);
         end
         if (done) begin
            done_cnt++;
            chk("active_at_done", 32'(active), 0);
         end
         prev_iss = addr_sel;
         prev_va  = vram_addr;
      end
   end

   task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      ce_b = 1'b0; we_b = 1'b0; cpu_addr = a; cpu_data = d;
      @(posedge clk); #1;
      ce_b = 1'b1; we_b = 1'b1;
   endtask

   task automatic mon_clear();
      iss_va.delete(); wr_ca.delete(); wr_d.delete();
      prev_iss = 1'b0; done_cnt = 0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_active"},   32'(active), 0);
      chk({tag, "_done"},     32'(done), 0);
      chk({tag, "_drive"},    32'(ram_drive), 0);
      chk({tag, "_addr_sel"}, 32'(addr_sel), 0);
      chk({tag, "_oe_b"},     32'(oe_b), 1);
      chk({tag, "_we_b"},     32'(ram_we_b), 1);
      chk({tag, "_vaddr"},    vram_addr, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_data"}, ram_data, 0);
      chk({tag, "_ram_page"}, ram_page, 0);
   endtask

   // Program (optionally), start, run to completion and compare against the rectangle model
   task automatic run_copy(input logic [7:0] sx, input logic [7:0] sy, input logic [12:0] dst,
                           input logic [1:0] pg, input logic [7:0] w, input logic [7:0] h,
                           input int abort_at, input bit mid_wr, input bit wr_regs);
      logic [15:0] exp_va [$];
      logic [12:0] exp_ca [$];
      int          n_exp;
      bit          ab_sent = 0;
      bit          ab_clr  = 0;
      for (int r = 0; r <= int'(h); r++)
         for (int c = 0; c <= int'(w); c++) begin
            exp_va.push_back({8'((int'(sy) + r) % 256), 8'((int'(sx) + c) % 256)});
            exp_ca.push_back(13'((int'(dst) + exp_ca.size()) % 8192));
         end
      n_exp = (abort_at > 0 && abort_at < exp_va.size()) ? abort_at : exp_va.size();
      cur_page = pg;
      mon_clear();
      mon_en = 1;
      if (wr_regs) begin
         reg_wr(3'd0, sx);
         reg_wr(3'd1, sy);
         reg_wr(3'd2, dst[7:0]);
         reg_wr(3'd3, {1'b0, pg, dst[12:8]});
         reg_wr(3'd4, w);
         reg_wr(3'd5, h);
      end
      reg_wr(3'd7, 8'h01);
      if (mid_wr) begin
         reg_wr(3'd0, 8'h77);
         reg_wr(3'd7, 8'h01);
      end
      for (int cyc = 0; cyc < 5000 && done_cnt == 0; cyc++) begin
         @(posedge clk); #1;
         if (ab_clr) begin
            ce_b = 1'b1; we_b = 1'b1; ab_clr = 0;
         end else if (abort_at > 0 && !ab_sent && iss_va.size() >= abort_at) begin
            ce_b = 1'b0; we_b = 1'b0; cpu_addr = 3'd7; cpu_data = 8'h80;
            ab_sent = 1; ab_clr = 1;
         end
      end
      ce_b = 1'b1; we_b = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt, 1);
      chk("active_after", 32'(active), 0);
      chk("drive_after", 32'(ram_drive), 0);
      chk("issue_count", iss_va.size(), n_exp);
      chk("write_count", wr_ca.size(), n_exp);
      for (int i = 0; i < n_exp; i++) begin
         if (i < iss_va.size()) chk("issue_addr", iss_va[i], exp_va[i]);
         if (i < wr_ca.size()) begin
            chk("write_addr", wr_ca[i], exp_ca[i]);
            chk("write_data", wr_d[i], vram[exp_va[i]]);
         end
      end
      mon_en = 0;
   endtask

   initial begin
      rst_b = 1'b0; ce_b = 1'b1; we_b = 1'b1; cpu_addr = '0; cpu_data = '0; free = 1'b1;
      for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);
      vram[16'h140A] = 8'h11;
      vram[16'h140B] = 8'h22;
      vram[16'h150A] = 8'h33;
      vram[16'h150B] = 8'h44;

      #30;
      reset_checks("rst_idle");
      @(posedge clk); #5 rst_b = 1'b1;

      free_mode = 0;
      run_copy(8'h0A, 8'h14, 13'h0100, 2'd1, 8'd1, 8'd1, 0, 0, 1);
      free_mode = 2;
      run_copy(8'h0A, 8'h14, 13'h0100, 2'd1, 8'd1, 8'd1, 0, 0, 1);
      free_mode = 0;
      run_copy(8'hFF, 8'h14, 13'h1FFF, 2'd2, 8'd1, 8'd0, 0, 0, 1);
      free_mode = 1;
      run_copy(8'h30, 8'h40, 13'h0800, 2'd3, 8'd7, 8'd7, 3, 0, 1);
      run_copy(8'hFC, 8'hFE, 13'h1FF0, 2'd0, 8'd7, 8'd3, 0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         free_mode = $urandom_range(0, 2);
         run_copy(8'($urandom), 8'($urandom), 13'($urandom), 2'($urandom),
                  8'($urandom_range(0, 9)), 8'($urandom_range(0, 5)), 0, 0, 1);
      end

      // Asynchronous reset in the middle of a copy
      free_mode = 0;
      reg_wr(3'd0, 8'h21);
      reg_wr(3'd3, 8'h45);
      reg_wr(3'd4, 8'd7);
      reg_wr(3'd5, 8'd7);
      reg_wr(3'd7, 8'h01);
      repeat (5) @(posedge clk);
      #1;
      chk("pre_reset_active", 32'(active), 1);
      #4 rst_b = 1'b0;
      #1 reset_checks("rst_run");
      @(posedge clk); #3;
      reset_checks("rst_hold");
      @(posedge clk); #5 rst_b = 1'b1;
      mon_clear();
      mon_en = 1;
      repeat (6) @(negedge clk);
      mon_en = 0;
      chk("post_reset_done", done_cnt, 0);
      chk("post_reset_writes", wr_ca.size(), 0);
      chk("post_reset_active", 32'(active), 0);
      // Registers were cleared: a bare start copies one pixel (0,0) to page 0 address 0
      run_copy(8'h00, 8'h00, 13'h0000, 2'd0, 8'd0, 8'd0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
